// File: rtl/pipe_stage_pkg.sv
// pipe_stage_pkg -- shared definitions for the pipe_stage_reg slice.
//   state_e        : occupancy state of the stage (EMPTY / ONE / TWO)
//   DEF_WIDTH      : default PC / instruction field width
//   DEF_NOP_INSTR  : default bubble encoding (all-ones, sliced to WIDTH;
//                    widths above 64 bits are not supported)
package pipe_stage_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    localparam int unsigned DEF_WIDTH     = 16;
    localparam logic [63:0] DEF_NOP_INSTR = '1;

endpackage

// File: rtl/pipe_stage_entry.sv
// pipe_stage_entry -- one payload slot (pc, pc+1, instr).
//   clock, reset_n : clock / async active-low reset (clears slot)
//   clr_i          : synchronous clear to (0, 0, NOP_INSTR); wins over ld_i
//   ld_i           : load pc_i / pc_plus1_i / instr_i
//   pc_o, pc_plus1_o, instr_o : registered slot contents
module pipe_stage_entry
    import pipe_stage_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] NOP_INSTR = DEF_NOP_INSTR[WIDTH-1:0]
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clr_i,
    input  logic             ld_i,
    input  logic [WIDTH-1:0] pc_i,
    input  logic [WIDTH-1:0] pc_plus1_i,
    input  logic [WIDTH-1:0] instr_i,
    output logic [WIDTH-1:0] pc_o,
    output logic [WIDTH-1:0] pc_plus1_o,
    output logic [WIDTH-1:0] instr_o
);

    logic [WIDTH-1:0] pc_q, pc_plus1_q, instr_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q       <= '0;
            pc_plus1_q <= '0;
            instr_q    <= NOP_INSTR;
        end else if (clr_i) begin
            pc_q       <= '0;
            pc_plus1_q <= '0;
            instr_q    <= NOP_INSTR;
        end else if (ld_i) begin
            pc_q       <= pc_i;
            pc_plus1_q <= pc_plus1_i;
            instr_q    <= instr_i;
        end
    end

    assign pc_o       = pc_q;
    assign pc_plus1_o = pc_plus1_q;
    assign instr_o    = instr_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg -- valid/ready pipeline register for (pc, pc+1, instr).
//   clock, reset_n          : clock / async active-low reset
//   flush                   : synchronous discard of everything held
//   valid_in, ready_out     : upstream handshake
//   pc_in, pc_plus1_in, instr_in : upstream payload
//   valid_out, ready_in     : downstream handshake
//   pc_out, pc_plus1_out, instr_out : downstream payload, idle = (0,0,NOP)
//   occupancy               : entries held (0..2)
// Macro PIPE_STAGE_SKID_EN: two-entry skid buffer with registered
// ready_out. Undefined: single entry, ready_out = ready_in || !valid_out.
module pipe_stage_reg
    import pipe_stage_pkg::*;
#(
    parameter int unsigned      WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] NOP_INSTR = DEF_NOP_INSTR[WIDTH-1:0]
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             valid_in,
    output logic             ready_out,
    input  logic [WIDTH-1:0] pc_in,
    input  logic [WIDTH-1:0] pc_plus1_in,
    input  logic [WIDTH-1:0] instr_in,
    output logic             valid_out,
    input  logic             ready_in,
    output logic [WIDTH-1:0] pc_out,
    output logic [WIDTH-1:0] pc_plus1_out,
    output logic [WIDTH-1:0] instr_out,
    output logic [1:0]       occupancy
);

    state_e           state_q, state_d;
    logic             acc, cons;
    logic             main_ld, main_clr;
    logic [WIDTH-1:0] main_pc_d, main_pc1_d, main_instr_d;

    assign valid_out = (state_q != ST_EMPTY);
    assign cons      = valid_out & ready_in;

`ifdef PIPE_STAGE_SKID_EN
    logic             skid_ld, skid_clr, main_from_skid;
    logic             ready_q;
    logic [1:0]       occ_q;
    logic [WIDTH-1:0] skid_pc, skid_pc1, skid_instr;

    assign ready_out = ready_q;
    assign occupancy = occ_q;
    assign acc       = valid_in & ready_q;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_clr       = 1'b0;
        skid_ld        = 1'b0;
        skid_clr       = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: if (acc) begin
                    state_d = ST_ONE;
                    main_ld = 1'b1;
                end
                ST_ONE: begin
                    if (acc && cons) begin
                        main_ld = 1'b1;
                    end else if (acc) begin
                        // output is stalled: park the new entry in the skid slot
                        state_d = ST_TWO;
                        skid_ld = 1'b1;
                    end else if (cons) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                ST_TWO: if (cons) begin
                    // ready_out is 0 here, so no accept can coincide
                    state_d        = ST_ONE;
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    skid_clr       = 1'b1;
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                    skid_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_pc_d    = main_from_skid ? skid_pc    : pc_in;
    assign main_pc1_d   = main_from_skid ? skid_pc1   : pc_plus1_in;
    assign main_instr_d = main_from_skid ? skid_instr : instr_in;

    // ready/occupancy are registered from the next state so neither
    // depends combinationally on ready_in
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q <= 1'b1;
            occ_q   <= 2'd0;
        end else begin
            ready_q <= (state_d != ST_TWO);
            occ_q   <= state_d;
        end
    end

    pipe_stage_entry #(.WIDTH(WIDTH), .NOP_INSTR(NOP_INSTR)) u_skid (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr_i      (skid_clr),
        .ld_i       (skid_ld),
        .pc_i       (pc_in),
        .pc_plus1_i (pc_plus1_in),
        .instr_i    (instr_in),
        .pc_o       (skid_pc),
        .pc_plus1_o (skid_pc1),
        .instr_o    (skid_instr)
    );
`else
    assign ready_out = ready_in | ~valid_out;
    assign occupancy = {1'b0, valid_out};
    assign acc       = valid_in & ready_out;

    always_comb begin
        state_d  = state_q;
        main_ld  = 1'b0;
        main_clr = 1'b0;
        if (flush) begin
            state_d  = ST_EMPTY;
            main_clr = 1'b1;
        end else begin
            case (state_q)
                ST_EMPTY: if (acc) begin
                    state_d = ST_ONE;
                    main_ld = 1'b1;
                end
                ST_ONE: begin
                    if (acc) begin
                        main_ld = 1'b1;
                    end else if (cons) begin
                        state_d  = ST_EMPTY;
                        main_clr = 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_EMPTY;
                    main_clr = 1'b1;
                end
            endcase
        end
    end

    assign main_pc_d    = pc_in;
    assign main_pc1_d   = pc_plus1_in;
    assign main_instr_d = instr_in;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= ST_EMPTY;
        else          state_q <= state_d;
    end

    // main slot is cleared whenever the stage goes empty, so the idle
    // (0, 0, NOP) outputs come straight from its register
    pipe_stage_entry #(.WIDTH(WIDTH), .NOP_INSTR(NOP_INSTR)) u_main (
        .clock      (clock),
        .reset_n    (reset_n),
        .clr_i      (main_clr),
        .ld_i       (main_ld),
        .pc_i       (main_pc_d),
        .pc_plus1_i (main_pc1_d),
        .instr_i    (main_instr_d),
        .pc_o       (pc_out),
        .pc_plus1_o (pc_plus1_out),
        .instr_o    (instr_out)
    );

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, giving the width of each PC and instruction field.
REQ-002 The module SHALL have parameter NOP_INSTR, default all-ones of WIDTH bits, giving the bubble instruction encoding.
REQ-003 The module SHALL have port clock, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit, asynchronous active-low reset.
REQ-005 The module SHALL have port flush, input, 1 bit, a synchronous discard of all held entries.
REQ-006 The module SHALL have ports valid_in (input, 1) and ready_out (output, 1), the upstream handshake.
REQ-007 The module SHALL have ports pc_in, pc_plus1_in and instr_in, each input, WIDTH bits, the upstream payload.
REQ-008 The module SHALL have ports valid_out (output, 1) and ready_in (input, 1), the downstream handshake.
REQ-009 The module SHALL have ports pc_out, pc_plus1_out and instr_out, each output, WIDTH bits, the downstream payload.
REQ-010 The module SHALL have port occupancy, output, 2 bits, giving the number of held entries (0..2).

Function
REQ-011 An entry SHALL be accepted when valid_in && ready_out at a rising edge, and SHALL be consumed when valid_out && ready_in at a rising edge.
REQ-012 Latency SHALL be 1 cycle: an entry accepted into an empty stage appears on the outputs with valid_out=1 in the following cycle.
REQ-013 Entries SHALL leave the stage in acceptance order; none SHALL be dropped or duplicated, except on flush.
REQ-014 While valid_out=0, outputs SHALL be pc_out=0, pc_plus1_out=0 and instr_out=NOP_INSTR.
REQ-015 While valid_out=1 && ready_in=0, the output payload SHALL be held stable.
REQ-016 With skid enabled, states SHALL be EMPTY, ONE and TWO. EMPTY goes to ONE on accept. ONE goes to TWO on accept without consume, stays in ONE on accept with consume, and goes to EMPTY on consume without accept. TWO goes to ONE on consume; accept is impossible in TWO.
REQ-017 With skid enabled, ready_out SHALL be a register output that equals 1 in EMPTY and ONE and 0 in TWO, with no combinational path from ready_in.
REQ-018 On TWO→ONE, the skid entry SHALL move to the output register in the same edge.
REQ-019 Flush SHALL take priority over simultaneous accept and consume. The next state is EMPTY, the input that cycle is discarded, and outputs revert to the REQ-014 values.
REQ-020 occupancy SHALL equal 0, 1 or 2 for EMPTY, ONE or TWO, and SHALL be a register output.

Reset
REQ-021 Asserting reset_n=0 SHALL immediately force the following, regardless of clock: state EMPTY, valid_out=0, pc_out=0, pc_plus1_out=0, instr_out=NOP_INSTR, occupancy=0.
REQ-022 Asserting reset_n=0 SHALL also immediately force ready_out=1 and clear the skid entry.
REQ-023 Reset mid-transfer SHALL discard all held entries; the first edge after release behaves as EMPTY.

Configuration
REQ-024 Macro PIPE_STAGE_SKID_EN defined SHALL give the two-entry skid behaviour of REQ-016 to REQ-018.
REQ-025 Macro PIPE_STAGE_SKID_EN undefined SHALL give a single entry with ready_out = ready_in || !valid_out (combinational), occupancy limited to 0 or 1, and skid storage absent.

Structure
REQ-026 Shared package pipe_stage_pkg SHALL hold the state-encoding typedef (EMPTY/ONE/TWO), the default WIDTH constant and the default NOP_INSTR constant.
REQ-027 One sub-module pipe_stage_entry SHALL implement a WIDTH×3 payload register with load enable and clear to (0, 0, NOP_INSTR), instantiated as the main entry and, when skid is enabled, the skid entry.

Verification
REQ-028 Streaming scenario: reset, then valid_in=1 and ready_in=1 for 4 cycles with instr_in=0x1001..0x1004 -> instr_out=0x1001..0x1004 one cycle later each, and occupancy stays ≤1.
REQ-029 Backpressure scenario (skid enabled): ready_in=0 while feeding instr_in=0xA001 and 0xA002 -> occupancy=2 and ready_out=0; then ready_in=1 -> 0xA001 then 0xA002 are output, ready_out=1.
REQ-030 Flush scenario: flush=1 in state TWO with valid_in=1 and instr_in=0xBEEF -> next cycle valid_out=0, instr_out=0xFFFF, occupancy=0, and 0xBEEF never appears.
REQ-031 Async reset scenario: reset_n=0 mid-cycle in state ONE with instr_out=0x1234 -> outputs clear without a clock edge (instr_out=0xFFFF, valid_out=0, ready_out=1).
REQ-032 Parametric scenario: WIDTH=32, NOP_INSTR=0x00000013, macro undefined, ready_in=0 after one accept -> ready_out=0, the payload is held, the idle output is 0x00000013.
REQ-033 Random scenario: randomised valid_in, ready_in and flush over 10,000 cycles against a scoreboard -> order is preserved, there is no loss outside flush, and payload stability holds under stall.
